branch_predictor: RTL and testbench

Direct-mapped branch target buffer with 2-bit saturating direction counters for the RV64 pipeline. Supplies a next-PC prediction to IF in the same cycle, and resolves conditional branches and JAL in EX from the comparator result (`cmp_res`), `cmp_op` and the computed target. Raises a same-cycle redirect on mispredict and trains the table on the following clock edge. Also keeps resolved-branch and mispredict counters for performance reporting.

---
 rtl/branch_predictor_pkg.sv | 29 ++
 rtl/bp_table.sv | 39 +++
 rtl/branch_predictor.sv | 125 ++++++++++++
 tb/tb_branch_predictor.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/branch_predictor_pkg.sv
// Shared types and constants for the branch target buffer and direction predictor.
package branch_predictor_pkg;

  // Comparator operation carried with an EX-stage instruction.
  typedef enum logic [2:0] {
    CMP_NO,
    CMP_EQ,
    CMP_NE,
    CMP_LT,
    CMP_GE,
    CMP_LTU,
    CMP_GEU
  } cmp_op_enum;

  // Tags are stored zero-extended to this width so the entry type stays fixed.
  localparam int unsigned BP_TAG_MAX_W = 32;

  localparam logic [1:0] BP_CTR_WT  = 2'd2;
  localparam logic [1:0] BP_CTR_ST  = 2'd3;
  localparam logic [1:0] BP_CTR_RST = 2'd1;

  typedef struct packed {
    logic                    valid;
    logic [BP_TAG_MAX_W-1:0] tag;
    logic [63:0]             target;
    logic [1:0]              ctr;
  } bp_entry_t;

endpackage

// File: rtl/bp_table.sv
// Direct-mapped entry array: two combinational read ports, one synchronous write port.
// Reset clears valid bits and parks every counter at weakly not-taken.
module bp_table
  import branch_predictor_pkg::*;
#(
  parameter int unsigned ENTRIES = 16,
  localparam int unsigned IDX_W  = $clog2(ENTRIES)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [IDX_W-1:0] rd_a_idx,
  output bp_entry_t        rd_a_entry,
  input  logic [IDX_W-1:0] rd_b_idx,
  output bp_entry_t        rd_b_entry,
  input  logic             we,
  input  logic [IDX_W-1:0] wr_idx,
  input  bp_entry_t        wr_entry
);

  bp_entry_t mem_q [ENTRIES];

  // Reset wins over a write in the same cycle; tags and targets stay as they were.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int i = 0; i < int'(ENTRIES); i++) begin
        mem_q[i].valid <= 1'b0;
        mem_q[i].ctr   <= BP_CTR_RST;
      end
    end else if (we) begin
      mem_q[wr_idx] <= wr_entry;
    end
  end

  always_comb begin
    rd_a_entry = mem_q[rd_a_idx];
    rd_b_entry = mem_q[rd_b_idx];
  end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit direction counters: same-cycle fetch prediction,
// EX-stage resolution with combinational redirect, next-edge training and stats.
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int unsigned ENTRIES = 16,
  parameter int unsigned TAG_W   = 8
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [63:0] if_pc,
  output logic        pred_taken,
  output logic [63:0] pred_target,
  input  logic        ex_valid,
  input  logic        ex_is_branch,
  input  logic        ex_is_jal,
  input  cmp_op_enum  ex_cmp_op,
  input  logic        ex_cmp_res,
  input  logic [63:0] ex_pc,
  input  logic [63:0] ex_target,
  input  logic        ex_pred_taken,
  input  logic [63:0] ex_pred_target,
  output logic        redirect,
  output logic [63:0] redirect_pc,
  output logic [31:0] br_cnt,
  output logic [31:0] miss_cnt
);

  localparam int unsigned IDX_W = $clog2(ENTRIES);

  function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic taken);
    if (taken) begin
      return (ctr == BP_CTR_ST) ? ctr : ctr + 2'd1;
    end
    return (ctr == 2'd0) ? ctr : ctr - 2'd1;
  endfunction

  logic [IDX_W-1:0] if_idx, ex_idx;
  logic [TAG_W-1:0] if_tag, ex_tag;
  bp_entry_t        if_entry, ex_entry, wr_entry;
  logic             if_hit, ex_hit, we;
  logic             resolve, taken;
  logic [63:0]      act_pc;
  logic [31:0]      br_cnt_q, miss_cnt_q;

  assign if_idx = if_pc[IDX_W+1:2];
  assign if_tag = if_pc[IDX_W+TAG_W+1:IDX_W+2];
  assign ex_idx = ex_pc[IDX_W+1:2];
  assign ex_tag = ex_pc[IDX_W+TAG_W+1:IDX_W+2];

  bp_table #(
    .ENTRIES(ENTRIES)
  ) u_table (
    .clk       (clk),
    .rstn      (rstn),
    .rd_a_idx  (if_idx),
    .rd_a_entry(if_entry),
    .rd_b_idx  (ex_idx),
    .rd_b_entry(ex_entry),
    .we        (we),
    .wr_idx    (ex_idx),
    .wr_entry  (wr_entry)
  );

  // Fetch lookup; gated by rstn so nothing stale leaks out while reset is held.
  always_comb begin
    if_hit      = if_entry.valid && (if_entry.tag == BP_TAG_MAX_W'(if_tag));
    pred_taken  = rstn && if_hit && if_entry.ctr[1];
    pred_target = pred_taken ? if_entry.target : if_pc + 64'd4;
  end

  // A conditional branch with no comparator op is not a control transfer.
  always_comb begin
    resolve     = ex_valid && (ex_is_jal || (ex_is_branch && (ex_cmp_op != CMP_NO)));
    taken       = ex_is_jal || ex_cmp_res;
    act_pc      = taken ? ex_target : ex_pc + 64'd4;
    redirect    = resolve &&
                  ((taken != ex_pred_taken) || (taken && (ex_pred_target != ex_target)));
    redirect_pc = act_pc;
  end

  always_comb begin
    ex_hit   = ex_entry.valid && (ex_entry.tag == BP_TAG_MAX_W'(ex_tag));
    we       = 1'b0;
    wr_entry = ex_entry;
    if (resolve) begin
      if (ex_hit) begin
        we = 1'b1;
        if (ex_is_jal) begin
          wr_entry.ctr    = BP_CTR_ST;
          wr_entry.target = ex_target;
        end else begin
          wr_entry.ctr = ctr_next(ex_entry.ctr, taken);
          if (taken) begin
            wr_entry.target = ex_target;
          end
        end
      end else if (taken) begin
        we              = 1'b1;
        wr_entry.valid  = 1'b1;
        wr_entry.tag    = BP_TAG_MAX_W'(ex_tag);
        wr_entry.target = ex_target;
        wr_entry.ctr    = ex_is_jal ? BP_CTR_ST : BP_CTR_WT;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      br_cnt_q   <= '0;
      miss_cnt_q <= '0;
    end else begin
      if (resolve) begin
        br_cnt_q <= br_cnt_q + 32'd1;
      end
      if (redirect) begin
        miss_cnt_q <= miss_cnt_q + 32'd1;
      end
    end
  end

  assign br_cnt   = rstn ? br_cnt_q : '0;
  assign miss_cnt = rstn ? miss_cnt_q : '0;

endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboard bench: stimulus pushes model expectations, a negedge monitor pops and compares.
module tb_branch_predictor;
  import branch_predictor_pkg::*;

  typedef struct {
    logic        rstn;
    logic [63:0] if_pc;
    logic        v;
    logic        br;
    logic        jal;
    cmp_op_enum  op;
    logic        res;
    logic [63:0] pc;
    logic [63:0] tgt;
    logic        ptk;
    logic [63:0] ptg;
  } stim_t;

  typedef struct {
    logic        pt;
    logic [63:0] ptg;
    logic        rd;
    logic [63:0] rpc;
    logic [31:0] bc;
    logic [31:0] mc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rstn;
  logic [63:0] if_pc;
  logic        pred_taken;
  logic [63:0] pred_target;
  logic        ex_valid, ex_is_branch, ex_is_jal, ex_cmp_res, ex_pred_taken;
  cmp_op_enum  ex_cmp_op;
  logic [63:0] ex_pc, ex_target, ex_pred_target;
  logic        redirect;
  logic [63:0] redirect_pc;
  logic [31:0] br_cnt, miss_cnt;

  int n_checks = 0;
  int n_err = 0;
  exp_t sb[$];

  // Reference state: what each of the 16 slots holds, as plain numbers.
  bit          m_valid [16];
  logic [7:0]  m_tag   [16];
  logic [63:0] m_tgt   [16];
  int          m_ctr   [16];
  logic [31:0] m_br = 0;
  logic [31:0] m_miss = 0;

  always #5 clk = ~clk;

  branch_predictor dut (
    .clk           (clk),
    .rstn          (rstn),
    .if_pc         (if_pc),
    .pred_taken    (pred_taken),
    .pred_target   (pred_target),
    .ex_valid      (ex_valid),
    .ex_is_branch  (ex_is_branch),
    .ex_is_jal     (ex_is_jal),
    .ex_cmp_op     (ex_cmp_op),
    .ex_cmp_res    (ex_cmp_res),
    .ex_pc         (ex_pc),
    .ex_target     (ex_target),
    .ex_pred_taken (ex_pred_taken),
    .ex_pred_target(ex_pred_target),
    .redirect      (redirect),
    .redirect_pc   (redirect_pc),
    .br_cnt        (br_cnt),
    .miss_cnt      (miss_cnt)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit m_hit(input logic [63:0] pc);
    return m_valid[pc[5:2]] && (m_tag[pc[5:2]] == pc[13:6]);
  endfunction

  function automatic bit m_pred(input logic [63:0] pc);
    return m_hit(pc) && (m_ctr[pc[5:2]] >= 2);
  endfunction

  function automatic stim_t idle(input logic [63:0] fpc);
    stim_t s;
    s.rstn = 1'b1; s.if_pc = fpc; s.v = 1'b0; s.br = 1'b0; s.jal = 1'b0; s.op = CMP_NO;
    s.res = 1'b0; s.pc = 64'h0; s.tgt = 64'h0; s.ptk = 1'b0; s.ptg = 64'h4;
    return s;
  endfunction

  function automatic stim_t branch(input logic [63:0] fpc, input logic [63:0] pc,
                                   input logic res, input logic [63:0] tgt,
                                   input logic ptk, input logic [63:0] ptg);
    stim_t s = idle(fpc);
    s.v = 1'b1; s.br = 1'b1; s.op = CMP_EQ; s.res = res; s.pc = pc; s.tgt = tgt;
    s.ptk = ptk; s.ptg = ptg;
    return s;
  endfunction

  // Drive one cycle, record the expected outputs, then advance the model past the edge.
  task automatic apply(input stim_t s);
    exp_t        e;
    bit          resolve, tk;
    int          i;
    @(posedge clk);
    #1;
    rstn = s.rstn; if_pc = s.if_pc; ex_valid = s.v; ex_is_branch = s.br; ex_is_jal = s.jal;
    ex_cmp_op = s.op; ex_cmp_res = s.res; ex_pc = s.pc; ex_target = s.tgt;
    ex_pred_taken = s.ptk; ex_pred_target = s.ptg;
    #1;
    e.pt  = s.rstn && m_pred(s.if_pc);
    e.ptg = e.pt ? m_tgt[s.if_pc[5:2]] : s.if_pc + 64'd4;
    resolve = s.v && (s.jal || (s.br && s.op != CMP_NO));
    tk = s.jal || s.res;
    e.rpc = tk ? s.tgt : s.pc + 64'd4;
    e.rd  = resolve && ((tk != s.ptk) || (tk && s.ptg != s.tgt));
    e.bc  = s.rstn ? m_br : 32'd0;
    e.mc  = s.rstn ? m_miss : 32'd0;
    sb.push_back(e);
    if (!s.rstn) begin
      for (int k = 0; k < 16; k++) begin
        m_valid[k] = 1'b0;
        m_ctr[k] = 1;
      end
      m_br = 0;
      m_miss = 0;
    end else if (resolve) begin
      i = int'(s.pc[5:2]);
      m_br = m_br + 1;
      if (e.rd) m_miss = m_miss + 1;
      if (m_hit(s.pc)) begin
        if (s.jal) begin
          m_ctr[i] = 3;
          m_tgt[i] = s.tgt;
        end else begin
          m_ctr[i] = tk ? ((m_ctr[i] == 3) ? 3 : m_ctr[i] + 1)
                        : ((m_ctr[i] == 0) ? 0 : m_ctr[i] - 1);
          if (tk) m_tgt[i] = s.tgt;
        end
      end else if (tk) begin
        m_valid[i] = 1'b1;
        m_tag[i] = s.pc[13:6];
        m_tgt[i] = s.tgt;
        m_ctr[i] = s.jal ? 3 : 2;
      end
    end
  endtask

  always @(negedge clk) begin
    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      check("pred_taken", 64'(pred_taken), 64'(e.pt));
      check("pred_target", pred_target, e.ptg);
      check("redirect", 64'(redirect), 64'(e.rd));
      check("redirect_pc", redirect_pc, e.rpc);
      check("br_cnt", 64'(br_cnt), 64'(e.bc));
      check("miss_cnt", 64'(miss_cnt), 64'(e.mc));
    end
  end

  initial begin
    stim_t s;
    s = idle(64'h100);
    s.rstn = 1'b0;
    apply(s);
    apply(s);
    apply(idle(64'h100));
    check("rst_pred_taken", 64'(pred_taken), 64'h0);
    check("rst_pred_target", pred_target, 64'h104);
    check("rst_br_cnt", 64'(br_cnt), 64'h0);

    // BEQ at 0x100 taken to 0x80, predicted not-taken.
    apply(branch(64'h100, 64'h100, 1'b1, 64'h80, 1'b0, 64'h104));
    check("beq_redirect", 64'(redirect), 64'h1);
    check("beq_redirect_pc", redirect_pc, 64'h80);
    apply(idle(64'h100));
    check("beq_pred_taken", 64'(pred_taken), 64'h1);
    check("beq_pred_target", pred_target, 64'h80);
    check("beq_miss_cnt", 64'(miss_cnt), 64'h1);

    // Not taken twice: counter 2 -> 1 -> 0, then one taken leaves it at 1.
    apply(branch(64'h100, 64'h100, 1'b0, 64'h80, 1'b1, 64'h80));
    check("nt1_redirect_pc", redirect_pc, 64'h104);
    apply(idle(64'h100));
    check("nt1_pred_taken", 64'(pred_taken), 64'h0);
    apply(branch(64'h100, 64'h100, 1'b0, 64'h80, 1'b0, 64'h104));
    check("nt2_redirect", 64'(redirect), 64'h0);
    apply(branch(64'h100, 64'h100, 1'b1, 64'h80, 1'b0, 64'h104));
    apply(idle(64'h100));
    check("sat0_pred_taken", 64'(pred_taken), 64'h0);

    // JAL at 0x200 aliases index 0 with a new tag and evicts 0x100.
    s = idle(64'h200);
    s.v = 1'b1; s.jal = 1'b1; s.pc = 64'h200; s.tgt = 64'h400; s.ptg = 64'h204;
    apply(s);
    check("jal_redirect", 64'(redirect), 64'h1);
    check("jal_redirect_pc", redirect_pc, 64'h400);
    apply(idle(64'h200));
    check("jal_pred_target", pred_target, 64'h400);
    apply(idle(64'h100));
    check("alias_evicted", 64'(pred_taken), 64'h0);
    apply(branch(64'h200, 64'h200, 1'b0, 64'h400, 1'b1, 64'h400));
    apply(idle(64'h200));
    check("jal_nt1_pred", 64'(pred_taken), 64'h1);
    apply(branch(64'h200, 64'h200, 1'b0, 64'h400, 1'b1, 64'h400));
    apply(idle(64'h200));
    check("jal_nt2_pred", 64'(pred_taken), 64'h0);
    apply(branch(64'h200, 64'h200, 1'b0, 64'h400, 1'b0, 64'h204));

    // Killed instruction and CMP_NO branch: no redirect, no write, no count.
    s = branch(64'h300, 64'h300, 1'b1, 64'h900, 1'b0, 64'h304);
    s.v = 1'b0;
    apply(s);
    check("killed_redirect", 64'(redirect), 64'h0);
    s.v = 1'b1; s.op = CMP_NO;
    apply(s);
    check("cmpno_redirect", 64'(redirect), 64'h0);
    apply(idle(64'h300));
    check("cmpno_no_write", 64'(pred_taken), 64'h0);

    // Same-cycle lookup and update at index 0: no bypass.
    s = idle(64'h300);
    s.v = 1'b1; s.jal = 1'b1; s.pc = 64'h300; s.tgt = 64'h900;
    apply(s);
    check("nobypass_old", 64'(pred_taken), 64'h0);
    apply(idle(64'h300));
    check("nobypass_new", pred_target, 64'h900);

    // Reset during an update drops the update.
    s = idle(64'h500);
    s.rstn = 1'b0; s.v = 1'b1; s.jal = 1'b1; s.pc = 64'h500; s.tgt = 64'h700;
    apply(s);
    apply(idle(64'h500));
    check("rst_drop_update", 64'(pred_taken), 64'h0);
    apply(idle(64'h300));
    check("rst_cleared", 64'(pred_taken), 64'h0);

    for (int n = 0; n < 600; n++) begin
      s = idle({$urandom(), $urandom()});
      s.if_pc[13:6] = 8'($urandom_range(0, 2));
      s.if_pc[1:0] = 2'b00;
      s.rstn = ($urandom_range(0, 99) != 0);
      s.v = ($urandom_range(0, 5) != 0);
      s.jal = ($urandom_range(0, 3) == 0);
      s.br = !s.jal && ($urandom_range(0, 5) != 0);
      s.op = cmp_op_enum'($urandom_range(0, 6));
      s.res = 1'($urandom());
      s.pc = {$urandom(), $urandom()};
      s.pc[13:6] = 8'($urandom_range(0, 2));
      s.pc[1:0] = 2'b00;
      if ($urandom_range(0, 1) == 0) s.if_pc = s.pc;
      s.tgt = 64'($urandom_range(0, 7)) << 4;
      if ($urandom_range(0, 1) == 0) begin
        s.ptk = m_pred(s.pc);
        s.ptg = s.ptk ? m_tgt[s.pc[5:2]] : s.pc + 64'd4;
      end else begin
        s.ptk = 1'($urandom());
        s.ptg = 64'($urandom_range(0, 7)) << 4;
      end
      apply(s);
    end

    @(posedge clk);
    @(negedge clk);
    #1;
    check("sb_drained", 64'(sb.size()), 64'h0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
